match_ctrl: RTL and testbench

MATCH_CTRL -- requirements
Module: match_ctrl

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/match_ctrl_if.sv | 32 +++
 rtl/match_timer.sv | 35 +++
 rtl/match_ctrl.sv | 159 +++++++++++++++
 tb/tb_match_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the arena game: match FSM states, winner codes,
// fixed player spawn coordinates and small scoring helpers.
package vga_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StActive,
    StCooldown,
    StOver
  } match_state_e;

  typedef enum logic [1:0] {
    WinNone = 2'b00,
    WinP1   = 2'b01,
    WinP2   = 2'b10,
    WinDraw = 2'b11
  } winner_e;

  // Player spawn tiles; a point must never be placed on top of a player.
  localparam logic [9:0] P1SpawnX = 10'd32;
  localparam logic [9:0] P1SpawnY = 10'd32;
  localparam logic [9:0] P2SpawnX = 10'd992;
  localparam logic [9:0] P2SpawnY = 10'd736;

  // Parked position of the point while no match is running.
  localparam logic [9:0] PointRstX = 10'd512;
  localparam logic [9:0] PointRstY = 10'd64;

  localparam logic [4:0] ScoreMax = 5'd31;

  function automatic logic on_spawn(logic [9:0] x, logic [9:0] y);
    return ((x == P1SpawnX) && (y == P1SpawnY)) || ((x == P2SpawnX) && (y == P2SpawnY));
  endfunction

  function automatic logic [4:0] score_inc(logic [4:0] s);
    return (s == ScoreMax) ? ScoreMax : s + 5'd1;
  endfunction

  function automatic winner_e score_winner(logic [4:0] s1, logic [4:0] s2);
    if (s1 > s2) return WinP1;
    if (s2 > s1) return WinP2;
    return WinDraw;
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Control/status bundle between the match controller and the rest of the game.
// master drives frame/player/placement inputs; slave is the controller itself.
interface match_ctrl_if;
  logic       tick;
  logic       start;
  logic       hit1;
  logic       hit2;
  logic       cand_valid;
  logic [9:0] cand_x;
  logic [9:0] cand_y;
  logic       spawn_req;
  logic [9:0] point_x;
  logic [9:0] point_y;
  logic       point_valid;
  logic [4:0] score1;
  logic [4:0] score2;
  logic [11:0] time_left;
  logic [1:0] winner;
  logic       game_over;

  modport master (
    output tick, start, hit1, hit2, cand_valid, cand_x, cand_y,
    input  spawn_req, point_x, point_y, point_valid, score1, score2, time_left, winner,
           game_over
  );

  modport slave (
    input  tick, start, hit1, hit2, cand_valid, cand_x, cand_y,
    output spawn_req, point_x, point_y, point_valid, score1, score2, time_left, winner,
           game_over
  );
endinterface

// File: rtl/match_timer.sv
// Loadable tick-down counter that stops at zero and flags when it is there.
module match_timer #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  // Load wins over decrement; decrement never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/match_ctrl.sv
// Match controller: spawns points, awards them to players, runs the cooldown
// between points and ends the match on target score or timer expiry.
module match_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned TARGET_SCORE   = 10,
  parameter int unsigned MATCH_TICKS    = 3600,
  parameter int unsigned COOLDOWN_TICKS = 30  // must be at least 1
) (
  input  logic         clk,
  input  logic         rst,
  match_ctrl_if.slave  ctrl_io
);

  localparam int unsigned CntW    = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(COOLDOWN_TICKS - 1);
  localparam logic [4:0]  Target    = 5'(TARGET_SCORE);
  localparam logic [11:0] MatchLoad = 12'(MATCH_TICKS);

  match_state_e    state_q, state_d;
  logic [9:0]      point_x_q, point_x_d, point_y_q, point_y_d;
  logic [4:0]      score1_q, score1_d, score2_q, score2_d;
  winner_e         winner_q, winner_d;
  logic            tie_q, tie_d;
  logic [CntW-1:0] cool_cnt_q, cool_cnt_d;

  logic        timer_load, timer_dec, timer_zero;
  logic [11:0] time_left;
  logic        award_p2;
  logic        reached;

  match_timer #(
    .Width (12)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (MatchLoad),
    .dec_i      (timer_dec),
    .count_o    (time_left),
    .zero_o     (timer_zero)
  );

  // Next-state, award and timer-control logic.
  always_comb begin
    state_d    = state_q;
    point_x_d  = point_x_q;
    point_y_d  = point_y_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    winner_d   = winner_q;
    tie_d      = tie_q;
    cool_cnt_d = cool_cnt_q;
    timer_load = 1'b0;
    award_p2   = 1'b0;
    reached    = 1'b0;
    timer_dec  = ctrl_io.tick &&
                 ((state_q == StSpawn) || (state_q == StActive) || (state_q == StCooldown));

    case (state_q)
      StIdle, StOver: begin
        if (ctrl_io.start) begin
          score1_d   = '0;
          score2_d   = '0;
          tie_d      = 1'b0;
          winner_d   = WinNone;
          cool_cnt_d = '0;
          timer_load = 1'b1;
          state_d    = StSpawn;
        end
      end
      StSpawn: begin
        if (timer_zero) begin
          winner_d = score_winner(score1_q, score2_q);
          state_d  = StOver;
        end else if (ctrl_io.cand_valid && !on_spawn(ctrl_io.cand_x, ctrl_io.cand_y)) begin
          point_x_d = ctrl_io.cand_x;
          point_y_d = ctrl_io.cand_y;
          state_d   = StActive;
        end
      end
      StActive: begin
        if (ctrl_io.hit1 || ctrl_io.hit2) begin
          // Simultaneous hits alternate between players, P1 first.
          award_p2 = ctrl_io.hit2 && (!ctrl_io.hit1 || tie_q);
          if (ctrl_io.hit1 && ctrl_io.hit2) tie_d = !tie_q;
          if (award_p2) begin
            score2_d = score_inc(score2_q);
            reached  = (score2_d == Target);
          end else begin
            score1_d = score_inc(score1_q);
            reached  = (score1_d == Target);
          end
          if (reached) begin
            winner_d = award_p2 ? WinP2 : WinP1;
            state_d  = StOver;
          end else if (timer_zero) begin
            winner_d = score_winner(score1_d, score2_d);
            state_d  = StOver;
          end else begin
            cool_cnt_d = '0;
            state_d    = StCooldown;
          end
        end else if (timer_zero) begin
          winner_d = score_winner(score1_q, score2_q);
          state_d  = StOver;
        end
      end
      StCooldown: begin
        if (timer_zero) begin
          winner_d = score_winner(score1_q, score2_q);
          state_d  = StOver;
        end else if (ctrl_io.tick) begin
          if (cool_cnt_q == CntLast) begin
            cool_cnt_d = '0;
            state_d    = StSpawn;
          end else begin
            cool_cnt_d = cool_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      point_x_q  <= PointRstX;
      point_y_q  <= PointRstY;
      score1_q   <= '0;
      score2_q   <= '0;
      winner_q   <= WinNone;
      tie_q      <= 1'b0;
      cool_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      point_x_q  <= point_x_d;
      point_y_q  <= point_y_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      winner_q   <= winner_d;
      tie_q      <= tie_d;
      cool_cnt_q <= cool_cnt_d;
    end
  end

  assign ctrl_io.spawn_req   = (state_q == StSpawn);
  assign ctrl_io.point_valid = (state_q == StActive);
  assign ctrl_io.game_over   = (state_q == StOver);
  assign ctrl_io.point_x     = point_x_q;
  assign ctrl_io.point_y     = point_y_q;
  assign ctrl_io.score1      = score1_q;
  assign ctrl_io.score2      = score2_q;
  assign ctrl_io.time_left   = time_left;
  assign ctrl_io.winner      = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: two instances (default and short-match parameters) share
// one stimulus stream; a behavioural model predicts both every cycle.
module tb_match_ctrl;

  typedef struct packed {
    logic        spawn_req;
    logic [9:0]  point_x;
    logic [9:0]  point_y;
    logic        point_valid;
    logic [4:0]  score1;
    logic [4:0]  score2;
    logic [11:0] time_left;
    logic [1:0]  winner;
    logic        game_over;
  } obs_t;

  function automatic int tgt_of(int k);   return (k == 0) ? 10 : 2;   endfunction
  function automatic int match_of(int k); return (k == 0) ? 3600 : 5; endfunction
  function automatic int cool_of(int k);  return (k == 0) ? 30 : 1;   endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, hit1 = 1'b0, hit2 = 1'b0, cand_valid = 1'b0;
  logic [9:0] cand_x = '0, cand_y = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    match_ctrl_if bus ();
    obs_t obs;
    assign bus.tick       = tick;
    assign bus.start      = start;
    assign bus.hit1       = hit1;
    assign bus.hit2       = hit2;
    assign bus.cand_valid = cand_valid;
    assign bus.cand_x     = cand_x;
    assign bus.cand_y     = cand_y;
    assign obs = {bus.spawn_req, bus.point_x, bus.point_y, bus.point_valid, bus.score1,
                  bus.score2, bus.time_left, bus.winner, bus.game_over};
    match_ctrl #(
      .TARGET_SCORE   ((g == 0) ? 10 : 2),
      .MATCH_TICKS    ((g == 0) ? 3600 : 5),
      .COOLDOWN_TICKS ((g == 0) ? 30 : 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl_io (bus)
    );
  end

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: a match is "running" between start and its end; within it the
  // point is either wanted, live, or the cooldown has ticks left.
  bit m_run[2], m_over[2], m_live[2], m_want[2], m_tie[2];
  int m_s1[2], m_s2[2], m_tl[2], m_win[2], m_px[2], m_py[2], m_cool[2];

  task automatic end_match(int k, int who);
    m_run[k] = 0; m_over[k] = 1; m_live[k] = 0; m_want[k] = 0; m_cool[k] = 0;
    m_win[k] = who;
  endtask

  task automatic model_step(int k);
    bit expired, awarded, reached;
    int who;
    if (rst) begin
      m_run[k] = 0; m_over[k] = 0; m_live[k] = 0; m_want[k] = 0; m_tie[k] = 0;
      m_s1[k] = 0; m_s2[k] = 0; m_tl[k] = 0; m_win[k] = 0; m_cool[k] = 0;
      m_px[k] = 512; m_py[k] = 64;
      return;
    end
    if (!m_run[k]) begin
      if (start) begin
        m_s1[k] = 0; m_s2[k] = 0; m_tl[k] = match_of(k); m_tie[k] = 0; m_win[k] = 0;
        m_run[k] = 1; m_over[k] = 0; m_want[k] = 1; m_live[k] = 0; m_cool[k] = 0;
      end
      return;
    end
    expired = (m_tl[k] == 0);
    awarded = 0; reached = 0; who = 0;
    if (m_live[k] && (hit1 || hit2)) begin
      if (hit1 && hit2) begin
        who = m_tie[k] ? 2 : 1;
        m_tie[k] = !m_tie[k];
      end else begin
        who = hit1 ? 1 : 2;
      end
      if (who == 1) begin
        if (m_s1[k] < 31) m_s1[k]++;
        reached = (m_s1[k] == tgt_of(k));
      end else begin
        if (m_s2[k] < 31) m_s2[k]++;
        reached = (m_s2[k] == tgt_of(k));
      end
      m_live[k] = 0;
      awarded = 1;
    end
    if (tick && m_tl[k] > 0) m_tl[k]--;
    if (reached) end_match(k, who);
    else if (expired) end_match(k, (m_s1[k] > m_s2[k]) ? 1 : (m_s2[k] > m_s1[k]) ? 2 : 3);
    else if (awarded) m_cool[k] = cool_of(k);
    else if (m_want[k] && cand_valid &&
             !((cand_x == 32 && cand_y == 32) || (cand_x == 992 && cand_y == 736))) begin
      m_px[k] = cand_x; m_py[k] = cand_y; m_live[k] = 1; m_want[k] = 0;
    end else if (m_cool[k] > 0 && tick) begin
      m_cool[k]--;
      if (m_cool[k] == 0) m_want[k] = 1;
    end
  endtask

  function automatic obs_t expected(int k);
    obs_t e;
    e.spawn_req   = m_want[k];
    e.point_x     = 10'(m_px[k]);
    e.point_y     = 10'(m_py[k]);
    e.point_valid = m_live[k];
    e.score1      = 5'(m_s1[k]);
    e.score2      = 5'(m_s2[k]);
    e.time_left   = 12'(m_tl[k]);
    e.winner      = 2'(m_win[k]);
    e.game_over   = m_over[k];
    return e;
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp_inst(int k, obs_t act);
    obs_t exp_o;
    exp_o = expected(k);
    n_chk++;
    if (act !== exp_o) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL cycle_cmp dut%0d t=%0t: got %h expected %h", k, $time, act, exp_o);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, g_dut[0].obs);
      cmp_inst(1, g_dut[1].obs);
    end
  end

  task automatic chk(string name, int act, int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    step();
  endtask

  task automatic cand(int x, int y);
    cand_valid = 1'b1; cand_x = 10'(x); cand_y = 10'(y);
    step();
    cand_valid = 1'b0;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    chk("rst_point_x", g_dut[0].obs.point_x, 512);
    chk("rst_point_y", g_dut[0].obs.point_y, 64);
    chk("rst_time_left", g_dut[0].obs.time_left, 0);
    chk("rst_spawn_req", g_dut[0].obs.spawn_req, 0);
    chk("rst_game_over", g_dut[0].obs.game_over, 0);

    // First spawn and latch.
    rst = 1'b0;
    start = 1'b1;
    step();
    chk("spawn_req_a", g_dut[0].obs.spawn_req, 1);
    chk("time_load_a", g_dut[0].obs.time_left, 3600);
    chk("time_load_b", g_dut[1].obs.time_left, 5);
    cand(320, 224);
    chk("latch_x", g_dut[0].obs.point_x, 320);
    chk("latch_y", g_dut[0].obs.point_y, 224);
    chk("latch_valid", g_dut[0].obs.point_valid, 1);

    // Held hit gives one award, then exact cooldown length.
    hit1 = 1'b1;
    repeat (5) step();
    hit1 = 1'b0;
    chk("held_hit_score1", g_dut[0].obs.score1, 1);
    chk("held_hit_valid", g_dut[0].obs.point_valid, 0);
    repeat (29) do_tick();
    chk("cool_29_ticks", g_dut[0].obs.spawn_req, 0);
    do_tick();
    chk("cool_30_ticks", g_dut[0].obs.spawn_req, 1);
    chk("time_after_30", g_dut[0].obs.time_left, 3570);
    chk("b_expired_over", g_dut[1].obs.game_over, 1);
    chk("b_expired_winner", g_dut[1].obs.winner, 1);

    // Spawn tiles are rejected.
    cand(32, 32);
    chk("rej_p1_spawn", g_dut[0].obs.spawn_req, 1);
    cand(992, 736);
    chk("rej_p2_valid", g_dut[0].obs.point_valid, 0);
    cand(64, 96);
    chk("accept_x", g_dut[0].obs.point_x, 64);
    chk("accept_y", g_dut[0].obs.point_y, 96);

    // Simultaneous hits alternate.
    hit1 = 1'b1; hit2 = 1'b1;
    step();
    hit1 = 1'b0; hit2 = 1'b0;
    chk("tie1_score1", g_dut[0].obs.score1, 2);
    chk("tie1_score2", g_dut[0].obs.score2, 0);
    repeat (30) do_tick();
    cand(100, 100);
    hit1 = 1'b1; hit2 = 1'b1;
    step();
    hit1 = 1'b0; hit2 = 1'b0;
    chk("tie2_score2", g_dut[0].obs.score2, 1);
    chk("tie2_score1", g_dut[0].obs.score1, 2);

    // Start mid-match ignored on a; restarts b from OVER.
    start = 1'b1;
    step();
    chk("start_ignored_a", g_dut[0].obs.score1, 2);
    chk("restart_b_score", g_dut[1].obs.score1, 0);
    chk("restart_b_over", g_dut[1].obs.game_over, 0);
    cand(200, 200);
    hit2 = 1'b1;
    step();
    hit2 = 1'b0;
    do_tick();
    cand(210, 210);
    hit2 = 1'b1;
    step();
    hit2 = 1'b0;
    chk("target_over_b", g_dut[1].obs.game_over, 1);
    chk("target_winner_b", g_dut[1].obs.winner, 2);
    start = 1'b1;
    step();
    chk("restart_clear_s2", g_dut[1].obs.score2, 0);
    chk("restart_spawn_b", g_dut[1].obs.spawn_req, 1);

    // Timer expiry with no scoring gives a draw one cycle after the last tick.
    repeat (4) do_tick();
    tick = 1'b1;
    step();
    chk("expiry_time_zero", g_dut[1].obs.time_left, 0);
    chk("expiry_not_yet", g_dut[1].obs.game_over, 0);
    step();
    chk("expiry_over", g_dut[1].obs.game_over, 1);
    chk("expiry_draw", g_dut[1].obs.winner, 3);

    // Reset during cooldown on a.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cool_rst_x", g_dut[0].obs.point_x, 512);
    chk("cool_rst_y", g_dut[0].obs.point_y, 64);
    chk("cool_rst_s1", g_dut[0].obs.score1, 0);
    chk("cool_rst_s2", g_dut[0].obs.score2, 0);
    chk("cool_rst_time", g_dut[0].obs.time_left, 0);
    chk("cool_rst_valid", g_dut[0].obs.point_valid, 0);
    chk("cool_rst_spawn", g_dut[0].obs.spawn_req, 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst        = ($urandom % 600) == 0;
      start      = ($urandom % 50) == 0;
      tick       = ($urandom % 3) == 0;
      hit1       = ($urandom % 5) == 0;
      hit2       = ($urandom % 5) == 0;
      cand_valid = ($urandom % 3) == 0;
      r = $urandom % 8;
      if (r == 0) begin
        cand_x = 10'd32; cand_y = 10'd32;
      end else if (r == 1) begin
        cand_x = 10'd992; cand_y = 10'd736;
      end else begin
        cand_x = 10'($urandom); cand_y = 10'($urandom);
      end
      step();
    end
    rst = 1'b0; hit1 = 1'b0; hit2 = 1'b0; cand_valid = 1'b0;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
